// File: rtl/rx_beamformer_pkg.sv
// rx_bf_pkg: shared constants, FSM state type and clamped per-channel delay for rx_beamformer.
package rx_bf_pkg;
  localparam int N_CH_DEF = 20;
  localparam int ADDR_W_DEF = 8;
  localparam int SUM_W = $clog2(N_CH_DEF + 1);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, OUT} state_t;
  function automatic int unsigned ch_delay(input int unsigned k, input int unsigned n_ch,
                                           input int unsigned step, input logic neg,
                                           input int unsigned max_d);
    int unsigned p;
    p = (neg ? n_ch - 1 - k : k) * step;
    return (p > max_d) ? max_d : p;
  endfunction
endpackage

// File: rtl/rx_beamformer_delay_ring_ram.sv
// delay_ring_ram: simple dual-port sample ring, one write port, registered read port, no reset.
module delay_ring_ram #(
  parameter int W = 20,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd_q
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[ra];
  end
endmodule

// File: rtl/rx_beamformer.sv
// rx_beamformer: decimates N_CH echo bits into a ring and emits one delay-and-sum count per sample.
// Optional threshold detect output enabled by defining RXBF_DETECT_EN.
module rx_beamformer
  import rx_bf_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIV = 50,
  parameter int STEP_W = 8
`ifdef RXBF_DETECT_EN
  , parameter int DET_THRESH = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             echo_in,
  input  logic [STEP_W-1:0]           step,
  input  logic                        steer_neg,
  output logic [$clog2(N_CH+1)-1:0]   sum,
  output logic                        sum_valid
`ifdef RXBF_DETECT_EN
  , output logic                      detect
`endif
);
  localparam int SW = $clog2(N_CH + 1);
  localparam int KW = $clog2(N_CH);
  localparam int CW = $clog2(DIV);
  localparam int DEPTH = 2 ** ADDR_W;
  if (DIV < N_CH + 4) begin : g_bad_div
    $error("rx_beamformer: DIV must be >= N_CH+4");
  end
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_addr, dly;
  logic [ADDR_W:0] fill_q, fill_d;
  logic [KW-1:0] k_q, k_d, rd_k_q;
  logic rd_en_q, rd_en_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic neg_q, neg_d;
  logic [SW-1:0] acc_q, acc_d, sum_q, sum_d;
  logic sum_valid_q, sum_valid_d;
  logic tick, bit_in;
  logic [N_CH-1:0] rd_data;
`ifdef RXBF_DETECT_EN
  logic detect_q, detect_d;
  assign detect = detect_q;
`endif
  delay_ring_ram #(.W(N_CH), .AW(ADDR_W)) u_ram (
    .clk (clk),
    .we  (state_q == IDLE && tick),
    .wa  (wr_ptr_q),
    .wd  (echo_in),
    .ra  (rd_addr),
    .rd_q(rd_data)
  );
  always_comb begin
    tick = cnt_q == CW'(DIV - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    dly = ADDR_W'(ch_delay(32'(k_q), N_CH, 32'(step_q), neg_q, DEPTH - 1));
    rd_addr = wr_ptr_q - dly;
    // Data returned this cycle belongs to the channel addressed last cycle.
    bit_in = rd_en_q & rd_data[rd_k_q];
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    fill_d = fill_q;
    k_d = k_q;
    rd_en_d = 1'b0;
    step_d = step_q;
    neg_d = neg_q;
    acc_d = acc_q;
    sum_d = sum_q;
    sum_valid_d = 1'b0;
    case (state_q)
      IDLE: if (tick) begin
        state_d = WRITE;
        step_d = step;
        neg_d = steer_neg;
        fill_d = (fill_q == (ADDR_W+1)'(DEPTH)) ? fill_q : fill_q + 1'b1;
      end
      WRITE: begin
        state_d = READ;
        k_d = '0;
        acc_d = '0;
      end
      READ: begin
        rd_en_d = {1'b0, dly} < fill_q;
        acc_d = acc_q + SW'(bit_in);
        k_d = k_q + 1'b1;
        state_d = (k_q == KW'(N_CH - 1)) ? DRAIN : READ;
      end
      DRAIN: begin
        state_d = OUT;
        sum_d = acc_q + SW'(bit_in);
        sum_valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    endcase
`ifdef RXBF_DETECT_EN
    detect_d = sum_valid_d ? (32'(sum_d) >= DET_THRESH) : detect_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_ptr_q <= '0;
      fill_q <= '0;
      k_q <= '0;
      rd_k_q <= '0;
      rd_en_q <= 1'b0;
      step_q <= '0;
      neg_q <= 1'b0;
      acc_q <= '0;
      sum_q <= '0;
      sum_valid_q <= 1'b0;
`ifdef RXBF_DETECT_EN
      detect_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q <= fill_d;
      k_q <= k_d;
      rd_k_q <= k_q;
      rd_en_q <= rd_en_d;
      step_q <= step_d;
      neg_q <= neg_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      sum_valid_q <= sum_valid_d;
`ifdef RXBF_DETECT_EN
      detect_q <= detect_d;
`endif
    end
  end
  assign sum = sum_q;
  assign sum_valid = sum_valid_q;
endmodule

// File: tb/tb_rx_beamformer.sv
// tb_rx_beamformer: sample-history model of delay-and-sum checked every cycle, plus literal spot checks.
module tb_rx_beamformer;
  localparam int N = 20;
  localparam int DIV = 50;
  localparam int DEPTH = 256;
  localparam int LAT = DIV + 22;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] echo_in = '0;
  logic [7:0] step = '0;
  logic steer_neg = 1'b0;
  logic [4:0] sum;
  logic sum_valid;
`ifdef RXBF_DETECT_EN
  logic detect;
  int exp_det = 0;
`endif
  rx_beamformer dut (
    .clk(clk), .rst(rst), .echo_in(echo_in), .step(step), .steer_neg(steer_neg),
    .sum(sum), .sum_valid(sum_valid)
`ifdef RXBF_DETECT_EN
    , .detect(detect)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, fails = 0, cyc = 0, s_next = 0, first_v = -1, exp_sum = 0;
  logic [N-1:0] hist [512];
  int hstep [512];
  logic hneg [512];
  int got [512];
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask
  function automatic int model_sum(input int f);
    int acc = 0;
    for (int i = 0; i < N; i++) begin
      int d = (hneg[f] ? N - 1 - i : i) * hstep[f];
      if (d > DEPTH - 1) d = DEPTH - 1;
      if (d <= f && hist[f-d][i]) acc++;
    end
    return acc;
  endfunction
  function automatic logic [N-1:0] echo_for(input int m, input int s);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++)
      v[i] = (m == 0) || (m == 1 && s == 100 - 3*i) || (m == 2 && s == 100 - 3*(N-1-i));
    return v;
  endfunction
  // Samples are taken every DIV cycles; a frame's sum is due LAT cycles after reset, then every DIV.
  always @(negedge clk) begin
    if (rst) begin
      exp_sum = 0;
      first_v = -1;
      for (int f = 0; f < 512; f++) got[f] = -1;
`ifdef RXBF_DETECT_EN
      exp_det = 0;
`endif
    end else begin
      int fr;
      logic ev;
      if (cyc % DIV == DIV - 1 && cyc / DIV < 512) begin
        hist[cyc/DIV] = echo_in;
        hstep[cyc/DIV] = step;
        hneg[cyc/DIV] = steer_neg;
      end
      ev = cyc >= LAT && (cyc - LAT) % DIV == 0;
      fr = ev ? (cyc - LAT) / DIV : 0;
      if (ev) exp_sum = model_sum(fr);
      chk("sum_valid", sum_valid, ev);
      chk("sum", sum, exp_sum);
      if (sum_valid && first_v < 0) first_v = cyc;
      if (ev && sum_valid && fr < 512) got[fr] = sum;
`ifdef RXBF_DETECT_EN
      if (ev) exp_det = exp_sum >= 16;
      chk("detect", detect, exp_det);
`endif
    end
  end
  task automatic adv_to(input int ph);
    do begin @(posedge clk); #1; end while (cyc % DIV != ph);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_next = 0;
  endtask
  task automatic frames(input int n, input int m, input logic [7:0] st, input logic ng,
                        input int chg, input logic [7:0] st2);
    step = st;
    steer_neg = ng;
    for (int j = 0; j < n; j++) begin
      echo_in = echo_for(m, s_next);
      if (s_next == chg) begin
        adv_to(5);
        step = st2;
      end
      adv_to(0);
      s_next++;
    end
  endtask
  task automatic drain();
    repeat (25) @(posedge clk);
    #1;
  endtask
  function automatic int max_except(input int n, input int skip);
    int mx = 0;
    for (int f = 0; f < n; f++) if (f != skip && got[f] > mx) mx = got[f];
    return mx;
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_sum", sum, 0);
    chk("rst_valid", sum_valid, 0);
    frames(5, 0, 8'd0, 1'b0, -1, 8'd0); drain();
    chk("t1_first_time", first_v, LAT);
    chk("t1_s0", got[0], 20);
    chk("t1_s4", got[4], 20);
    do_reset();
    frames(110, 1, 8'd3, 1'b0, -1, 8'd0); drain();
    chk("t2_s100", got[100], 20);
    chk("t2_others_le1", max_except(110, 100) <= 1, 1);
    do_reset();
    frames(110, 2, 8'd3, 1'b1, -1, 8'd0); drain();
    chk("t3_neg_s100", got[100], 20);
    do_reset();
    frames(110, 2, 8'd3, 1'b0, -1, 8'd0); drain();
    chk("t3_pos_le2", max_except(110, -1) <= 2, 1);
    do_reset();
    frames(200, 0, 8'd10, 1'b0, -1, 8'd0); drain();
    chk("t4_s0", got[0], 1);
    chk("t4_s25", got[25], 3);
    chk("t4_s140", got[140], 15);
    chk("t4_s150", got[150], 16);
    chk("t4_s190", got[190], 20);
    do_reset();
    frames(258, 0, 8'd20, 1'b0, -1, 8'd0); drain();
    chk("t5_s254", got[254], 13);
    chk("t5_s255", got[255], 20);
    chk("t5_s257", got[257], 20);
    do_reset();
    frames(33, 0, 8'd10, 1'b0, 31, 8'd1); drain();
    chk("chg_s30_old_step", got[30], 4);
    chk("chg_s31_new_step", got[31], 20);
    do_reset();
    frames(5, 0, 8'd0, 1'b0, -1, 8'd0);
    adv_to(10);
    do_reset();
    chk("abort_sum", sum, 0);
    chk("abort_valid", sum_valid, 0);
    frames(3, 0, 8'd10, 1'b0, -1, 8'd0); drain();
    chk("t6_first_time", first_v, LAT);
    chk("t6_s0_fill", got[0], 1);
    chk("t6_s2_fill", got[2], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/rx_beamformer.md
Name: rx_beamformer

Overview:
- Receive-side counterpart of the transmit phased-delay array: the TX path spreads one drive signal across 20 elements with per-element delays; this block recombines 20 echo inputs into one steered output.
- Decimates the 20 one-bit element comparator inputs to a sample rate.
- Stores the samples in a ring buffer and applies a per-channel delay of i*step (or (N_CH-1-i)*step when steering negative).
- Emits the delay-and-sum count once per sample period.
- Sits between the board's receive-element pins and the AVR/host readout.

Parameters:
- N_CH, 20, number of array elements.
- ADDR_W, 8, ring-buffer address width; DEPTH = 2**ADDR_W samples.
- DIV, 50, clk cycles per sample period; must be >= N_CH+4.
- STEP_W, 8, width of the step input.
- DET_THRESH, 16, detect threshold (used only with the optional feature).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- echo_in  in  N_CH  element comparator outputs, already synchronised upstream.
- step  in  STEP_W  inter-element delay in samples.
- steer_neg  in  1  0: delay_i = i*step; 1: delay_i = (N_CH-1-i)*step.
- sum  out  $clog2(N_CH+1)  delay-and-sum count, 0..N_CH.
- sum_valid  out  1  one-cycle pulse, sum updated.
- detect  out  1  present only when RXBF_DETECT_EN is defined.

Behaviour:
- Single clock domain, fully synchronous reset.
- Reset state:
  - sum=0, sum_valid=0, detect=0.
  - Divider count=0, wr_ptr=0, fill=0, FSM=IDLE.
- Sample tick:
  - The divider counts 0..DIV-1; tick is asserted when count==DIV-1.
  - The first tick occurs DIV cycles after reset deasserts.
- FSM states: IDLE, WRITE, READ, DRAIN, OUT.
- IDLE -> WRITE on tick:
  - Write echo_in to ring[wr_ptr].
  - Latch step and steer_neg; changes to them mid-frame are ignored.
  - fill = min(fill+1, DEPTH). fill is ADDR_W+1 bits and saturates.
- WRITE -> READ: next cycle. wr_ptr increments (mod DEPTH) at the end of the frame, not before the reads.
- READ, k = 0..N_CH-1, one per cycle:
  - Compute delay_k, clamped to DEPTH-1.
  - Read address = wr_ptr - delay_k (mod DEPTH).
  - RAM read latency is 1 cycle. The returned bit k is accumulated only if delay_k < fill; otherwise it is treated as 0 (warm-up, unwritten RAM).
  - After k = N_CH-1 -> DRAIN.
- DRAIN: accumulate the last read; -> OUT.
- OUT:
  - Register sum, pulse sum_valid for 1 cycle, increment wr_ptr.
  - -> IDLE.
- Latency: sum_valid asserts exactly N_CH+3 cycles after the tick cycle (23 for N_CH=20).
- Delay arithmetic:
  - Product width is STEP_W+$clog2(N_CH) bits, unsigned.
  - Clamp whenever the product exceeds DEPTH-1.
- Wrap-around: pointer arithmetic is modulo DEPTH. With delay=DEPTH-1 the read hits the oldest stored sample.
- Tick while not IDLE: cannot occur given DIV >= N_CH+4. An elaboration-time check rejects smaller DIV.
- Reset mid-frame: everything returns to the reset state; the partial sum is discarded and sum_valid is not pulsed.
- RAM contents are not reset; the fill gating guarantees that no stale data reaches sum after reset.

Optional Feature:
- Macro: RXBF_DETECT_EN.
- Defined:
  - detect port exists.
  - detect is registered in the OUT cycle: 1 if the new sum >= DET_THRESH, else 0.
  - It holds until the next OUT or reset.
- Undefined: no detect port and no comparator logic; all other behaviour is identical.

Decomposition:
- Package rx_bf_pkg:
  - Constants N_CH_DEF, ADDR_W_DEF, SUM_W = $clog2(N_CH+1).
  - State enum typedef (IDLE, WRITE, READ, DRAIN, OUT).
  - Function for the clamped channel delay.
- Sub-module delay_ring_ram:
  - Simple dual-port synchronous RAM, N_CH wide, DEPTH deep.
  - 1 write port, 1 read port with 1-cycle read latency; no reset.
  - Infers block RAM.

Test Plan:
1. step=0, echo_in=all ones held -> first sum_valid 23 cycles after the first tick with sum=20; every subsequent frame sum=20.
2. step=3, steer_neg=0, echo_in[i] pulses high for one sample at sample index 100-3i (after warm-up) -> sum=20 in the frame for sample 100; sum<=1 in all other frames.
3. step=3, steer_neg=1, echo_in[i] pulses at sample 100-3*(19-i) -> sum=20 at sample 100; the same stimulus with steer_neg=0 never exceeds 2.
4. step=10 right after reset, echo_in=all ones -> sum at sample index s = min(20, floor(s/10)+1): s=0 gives 1, s=25 gives 3, s>=190 gives 20.
5. step=20 (19*20=380 > 255) -> channels 13..19 clamped to delay 255; echo_in=all ones gives sum=13 until s=255 and 20 from s=255 on. Also change step mid-frame -> no effect until the next tick.
6. Assert rst for one cycle during READ, then rst=0 -> no sum_valid for the aborted frame; sum=0; the next sum_valid comes DIV+23 cycles after reset release with warm-up gating restarted (fill=1). With RXBF_DETECT_EN, DET_THRESH=16: sums 15 and 16 give detect 0 and 1.
